seg7_scan_driver: RTL
=====================

Name: seg7_scan_driver

Overview:
- Driver end of the multiplexed 7-segment display interface: converts a binary score (0..9999) to four BCD digits and time-multiplexes them.
- Each digit is presented in turn as digit index, 4-bit digit value and active-low dot. These feed directly into the segment decoder's SEG_SELECT_IN, BIN_IN and DOT_IN.
- Sits between the game score logic and the display decoder, and owns refresh timing.

Parameters:
- REFRESH_DIV, 100000, CLK cycles each digit stays selected (1 kHz per digit at 100 MHz); must be >= 2.
- VALUE_W, 14, width of VALUE_IN; fixed at 14 for the 0..9999 range.

Ports:
- CLK  input  1  system clock, all logic on rising edge
- RESET  input  1  synchronous, active-low reset
- VALUE_IN  input  14  binary value to display
- LOAD_IN  input  1  single-cycle request to capture VALUE_IN and convert
- DOT_MASK_IN  input  4  bit i high = dot lit on digit i (sampled live)
- SEG_SELECT_OUT  output  2  current digit index, 0 = rightmost
- BIN_OUT  output  4  BCD (or hex) value of current digit
- DOT_OUT  output  1  active-low dot for current digit
- BUSY_OUT  output  1  high while a conversion is in progress

Behaviour:
- Reset (RESET low at a rising edge):
  - SEG_SELECT_OUT=0, BIN_OUT=0, DOT_OUT=1, BUSY_OUT=0.
  - Display register = 0000, refresh counter = 0, FSM = IDLE.
  - Reset mid-conversion abandons it; the display register is also cleared.
- Refresh:
  - Counter runs 0..REFRESH_DIV-1 and wraps.
  - On the wrap edge, the digit index advances 0->1->2->3->0.
- Outputs (all registered):
  - SEG_SELECT_OUT = index.
  - BIN_OUT = display digit[index].
  - DOT_OUT = ~DOT_MASK_IN[index].
  - All three update on the same edge as the index, so they are always mutually consistent.
  - Refresh runs continuously, independent of conversion state.
- Clamp: VALUE_IN > 9999 is captured as 9999.
- FSM states:
  - IDLE: LOAD_IN=1 captures the clamped value, clears the BCD scratch and goes to SHIFT with bit counter = 13.
  - SHIFT: one double-dabble step per cycle. First add 3 to each BCD nibble >= 5, then shift {bcd, bin} left by 1. After the counter reaches 0, go to COMMIT (14 SHIFT cycles total).
  - COMMIT: copy scratch BCD to the display register, go to IDLE.
- Latency and BUSY:
  - If LOAD_IN is sampled at edge E0, BUSY_OUT is high from E0 to E15 (15 cycles).
  - The display register changes at E15.
  - New digits appear on BIN_OUT from the next output update edge at or after E15.
- LOAD_IN while BUSY_OUT=1 is ignored (no queueing); the current conversion completes unaffected.
- The display register only changes in COMMIT or reset, so there is no partially converted digit visible.
- Simultaneous COMMIT and refresh wrap on the same edge: outputs use the old display register for that edge; the new value is shown from the next wrap.

Optional Feature:
- Macro: SEG7_HEX_MODE_EN.
- Defined:
  - No BCD conversion and no clamp.
  - LOAD_IN in IDLE copies {2'b00, VALUE_IN} into the display register as four hex nibbles (digit0 = bits 3:0) on the sampling edge.
  - BUSY_OUT stays 0; the SHIFT/COMMIT states are not built.
- Undefined: decimal behaviour as above.

Test Plan:
- Reset with REFRESH_DIV=4, hold RESET low 3 cycles -> SEG_SELECT_OUT=0, BIN_OUT=0, DOT_OUT=1, BUSY_OUT=0.
- LOAD_IN pulse with VALUE_IN=1234:
  - BUSY_OUT high for exactly 15 cycles.
  - Scan then shows index 0..3 with BIN_OUT=4,3,2,1, each held 4 cycles, index wrapping 3->0.
- LOAD_IN with VALUE_IN=16383 -> digits 9,9,9,9 (clamp).
- LOAD_IN with VALUE_IN=0 -> digits 0,0,0,0.
- Second LOAD_IN (VALUE_IN=5678) pulsed 5 cycles into a conversion of 42:
  - Ignored; digits show 2,4,0,0.
  - BUSY_OUT falls at the same cycle as for a single load.
- DOT_MASK_IN=4'b0100 with 1234 loaded -> DOT_OUT=0 only when SEG_SELECT_OUT=2.
- RESET low 7 cycles into a conversion of 9999 -> BUSY_OUT=0 and digits 0000; no later commit.
- SEG7_HEX_MODE_EN build: VALUE_IN=14'h2A5F -> digits F,5,A,2 the cycle after load; BUSY_OUT never 1.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Score-to-digit scanner for a 4-digit multiplexed 7-segment display: double-dabble BCD conversion
// plus a free-running refresh scan. Define SEG7_HEX_MODE_EN to show raw hex nibbles instead.
module seg7_scan_driver #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned VALUE_W     = 14
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [VALUE_W-1:0] VALUE_IN,
    input  logic               LOAD_IN,
    input  logic [3:0]         DOT_MASK_IN,
    output logic [1:0]         SEG_SELECT_OUT,
    output logic [3:0]         BIN_OUT,
    output logic               DOT_OUT,
    output logic               BUSY_OUT
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [CNT_W-1:0] refresh_cnt;
    logic             wrap;
    logic [1:0]       next_sel;
    logic [3:0]       next_digit;
    logic [15:0]      display;

    assign wrap     = (refresh_cnt == CNT_W'(REFRESH_DIV - 1));
    assign next_sel = SEG_SELECT_OUT + 2'd1;

    always_comb begin
        next_digit = 4'd0;
        unique case (next_sel)
            2'd0: next_digit = display[3:0];
            2'd1: next_digit = display[7:4];
            2'd2: next_digit = display[11:8];
            2'd3: next_digit = display[15:12];
            default: next_digit = 4'd0;
        endcase
    end

    // Index, digit and dot all move together on the wrap edge so they never disagree.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            refresh_cnt    <= '0;
            SEG_SELECT_OUT <= 2'd0;
            BIN_OUT        <= 4'd0;
            DOT_OUT        <= 1'b1;
        end else if (wrap) begin
            refresh_cnt    <= '0;
            SEG_SELECT_OUT <= next_sel;
            BIN_OUT        <= next_digit;
            DOT_OUT        <= ~DOT_MASK_IN[next_sel];
        end else begin
            refresh_cnt    <= refresh_cnt + 1'b1;
        end
    end

`ifdef SEG7_HEX_MODE_EN

    assign BUSY_OUT = 1'b0;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            display <= 16'd0;
        end else if (LOAD_IN) begin
            display <= {{(16 - VALUE_W){1'b0}}, VALUE_IN};
        end
    end

`else

    typedef enum logic [1:0] {StIdle, StShift, StCommit} state_t;

    state_t             state;
    logic [3:0]         bit_cnt;
    logic [15:0]        bcd;
    logic [15:0]        bcd_adj;
    logic [VALUE_W-1:0] bin_sr;
    logic [VALUE_W-1:0] clamped;

    assign clamped = (VALUE_IN > VALUE_W'(9999)) ? VALUE_W'(9999) : VALUE_IN;

    // Double-dabble correction: any nibble >= 5 would overflow past 9 when doubled.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state    <= StIdle;
            bit_cnt  <= 4'd0;
            bcd      <= 16'd0;
            bin_sr   <= '0;
            display  <= 16'd0;
            BUSY_OUT <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (LOAD_IN) begin
                        bin_sr   <= clamped;
                        bcd      <= 16'd0;
                        bit_cnt  <= 4'(VALUE_W - 1);
                        state    <= StShift;
                        BUSY_OUT <= 1'b1;
                    end
                end
                StShift: begin
                    {bcd, bin_sr} <= {bcd_adj, bin_sr} << 1;
                    if (bit_cnt == 4'd0) begin
                        state <= StCommit;
                    end else begin
                        bit_cnt <= bit_cnt - 4'd1;
                    end
                end
                StCommit: begin
                    display  <= bcd;
                    state    <= StIdle;
                    BUSY_OUT <= 1'b0;
                end
                default: begin
                    state    <= StIdle;
                    BUSY_OUT <= 1'b0;
                end
            endcase
        end
    end

`endif

endmodule
